spi_reg_write_sequencer: RTL and testbench



---
 rtl/spi_reg_write_sequencer.sv | 121 ++++++++++++
 tb/tb_spi_reg_write_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_write_sequencer.sv
// SPI mode-0 write sequencer: turns accepted register writes into 16-bit frames
// {1'b1, addr[6:0], data[7:0]}, MSB first, with divided SCLK and an nCS gap.
module spi_reg_write_sequencer #(
  parameter int CLK_DIV  = 4,
  parameter int CS_GAP   = 4,
  parameter int MAX_ADDR = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       nCS,
  output logic       SCLK,
  output logic       COPI,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP} state_t;

  state_t      r_state, w_nextState;
  logic [DW-1:0] r_div;
  logic [GW-1:0] r_gap;
  logic [3:0]  r_bitCnt;
  logic [15:0] r_shift, w_shiftNext;
  logic        r_nCS, r_sclk, r_copi, r_busy, r_ready, r_done, r_err;
  logic        w_accept, w_addrOk, w_divLast, w_gapLast;
  logic        w_nCSNext, w_sclkNext, w_copiNext, w_busyNext, w_readyNext, w_doneNext, w_errNext;

  assign w_accept  = req_valid && r_ready;
  assign w_addrOk  = (req_addr <= 7'(MAX_ADDR));
  assign w_divLast = (r_div == DW'(CLK_DIV - 1));
  assign w_gapLast = (r_gap == GW'(CS_GAP - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:     if (w_accept && w_addrOk) w_nextState = SETUP;
      SETUP:    if (w_divLast) w_nextState = SHIFT_HI;
      SHIFT_HI: if (w_divLast) w_nextState = (r_bitCnt == 4'd15) ? HOLD : SHIFT_LO;
      SHIFT_LO: if (w_divLast) w_nextState = SHIFT_HI;
      HOLD:     if (w_divLast) w_nextState = GAP;
      GAP:      if (w_gapLast) w_nextState = IDLE;
      default:  w_nextState = IDLE;
    endcase
  end

  // Outputs are computed for the state being entered so every pin is a flop.
  always_comb begin
    w_shiftNext = r_shift;
    if (r_state == IDLE && w_nextState == SETUP)
      w_shiftNext = {1'b1, req_addr, req_data};
    else if (r_state == SHIFT_HI && w_nextState == SHIFT_LO)
      w_shiftNext = {r_shift[14:0], 1'b0};
    w_nCSNext   = !(w_nextState == SETUP || w_nextState == SHIFT_HI ||
                    w_nextState == SHIFT_LO || w_nextState == HOLD);
    w_sclkNext  = (w_nextState == SHIFT_HI);
    w_copiNext  = !w_nCSNext && w_shiftNext[15];
    w_busyNext  = (w_nextState != IDLE);
    w_readyNext = (w_nextState == IDLE);
    w_doneNext  = (r_state == HOLD) && (w_nextState == GAP);
    w_errNext   = w_accept && !w_addrOk;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div    <= '0;
      r_gap    <= '0;
      r_bitCnt <= '0;
      r_shift  <= '0;
      r_nCS    <= 1'b1;
      r_sclk   <= 1'b0;
      r_copi   <= 1'b0;
      r_busy   <= 1'b0;
      r_ready  <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_nextState != r_state || r_state == IDLE || r_state == GAP)
        r_div <= '0;
      else
        r_div <= r_div + DW'(1);
      if (r_state == GAP && w_nextState == GAP)
        r_gap <= r_gap + GW'(1);
      else
        r_gap <= '0;
      if (r_state == IDLE)
        r_bitCnt <= '0;
      else if (r_state == SHIFT_HI && w_nextState == SHIFT_LO)
        r_bitCnt <= r_bitCnt + 4'd1;
      r_shift <= w_shiftNext;
      r_nCS   <= w_nCSNext;
      r_sclk  <= w_sclkNext;
      r_copi  <= w_copiNext;
      r_busy  <= w_busyNext;
      r_ready <= w_readyNext;
      r_done  <= w_doneNext;
      r_err   <= w_errNext;
    end
  end

  assign req_ready = r_ready;
  assign nCS       = r_nCS;
  assign SCLK      = r_sclk;
  assign COPI      = r_copi;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_spi_reg_write_sequencer.sv
// Randomised bench: cycle-level timing model from frame arithmetic, an SPI
// target that decodes frames into a 5-entry register map, and directed cases.
module tb_spi_reg_write_sequencer;

  localparam int CLK_DIV  = 4;
  localparam int CS_GAP   = 4;
  localparam int MAX_ADDR = 4;
  localparam int FRAME    = 33 * CLK_DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic       req_ready, nCS, SCLK, COPI, busy, done, err;

  spi_reg_write_sequencer #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .MAX_ADDR(MAX_ADDR)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .nCS(nCS), .SCLK(SCLK),
    .COPI(COPI), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
  endtask

  // Reference model: a frame is just "cycles since acceptance" mapped onto phases.
  int          cyc = 0;
  bit          mActive = 0, mBooted = 0, mErr = 0, mAcc = 0;
  int          mK = 0;
  logic [15:0] mWord = '0;
  logic [15:0] expQ[$];
  int          acceptCyc[$];
  logic [7:0]  expReg[5] = '{default: 8'h00};

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      mActive = 0; mBooted = 0; mErr = 0;
      expQ.delete();
    end else begin
      cyc++;
      mAcc = mBooted && !mActive && req_valid;
      if (mActive) begin
        mK++;
        if (mK > FRAME + CS_GAP) mActive = 0;
      end
      mErr = 0;
      if (mAcc) begin
        if (req_addr <= 7'(MAX_ADDR)) begin
          mActive = 1; mK = 1;
          mWord = {1'b1, req_addr, req_data};
          expQ.push_back(mWord);
          acceptCyc.push_back(cyc);
        end else mErr = 1;
      end
      mBooted = 1;
    end
  end

  // Expected {nCS, SCLK, COPI, busy, req_ready, done, err}
  function automatic logic [6:0] expVec();
    int p, b;
    logic [6:0] v;
    if (mActive) begin
      if (mK <= FRAME) begin
        p = (mK - 1) / CLK_DIV;
        b = (p / 2 > 15) ? 0 : 15 - p / 2;
        v = {1'b0, 1'(p % 2), mWord[b], 1'b1, 1'b0, 1'b0, 1'b0};
      end else
        v = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'(mK == FRAME + 1), 1'b0};
    end else
      v = {1'b1, 1'b0, 1'b0, 1'b0, 1'(mBooted), 1'b0, 1'b0};
    v[0] = mErr;
    return v;
  endfunction

  int doneCnt = 0;
  initial forever begin
    @(negedge clk);
    checkOutput("cycle", 32'({nCS, SCLK, COPI, busy, req_ready, done, err}), 32'(expVec()));
    if (done) doneCnt++;
  end

  // SPI target: samples COPI on SCLK rise, commits only complete frames.
  int          ncsFalls = 0, sclkRises = 0, rxBits = 0;
  int          lastLow = 0, lastHigh = 0, riseCyc = -1, fallCyc = 0;
  bit          frameOpen = 0;
  logic [15:0] rxShift = '0;
  logic [15:0] rxQ[$];
  logic [15:0] expWord;
  logic [7:0]  tgt[5] = '{default: 8'h00};

  always @(negedge nCS) begin
    ncsFalls++;
    frameOpen = 1; rxBits = 0; rxShift = '0;
    if (riseCyc >= 0) lastHigh = cyc - riseCyc;
    fallCyc = cyc;
  end

  always @(posedge SCLK) begin
    if (nCS === 1'b0) begin
      rxShift = {rxShift[14:0], COPI};
      rxBits++;
      sclkRises++;
    end
  end

  always @(posedge nCS) begin
    riseCyc = cyc;
    if (frameOpen && !reset) begin
      lastLow = cyc - fallCyc;
      checkOutput("frameBits", 32'(rxBits), 32'd16);
      checkOutput("nCSLow", 32'(lastLow), 32'(FRAME));
      rxQ.push_back(rxShift);
      checkOutput("frameExpected", 32'(expQ.size()), 32'd1);
      if (expQ.size() > 0) begin
        expWord = expQ.pop_front();
        checkOutput("frameWord", 32'(rxShift), 32'(expWord));
      end
      if (rxShift[15] && rxShift[14:8] <= 7'(MAX_ADDR)) tgt[int'(rxShift[10:8])] = rxShift[7:0];
    end
    frameOpen = 0;
  end

  task automatic applyStimulus(input logic [6:0] a, input logic [7:0] d, input bit keep, input bit noise);
    int n;
    bit gotDone;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_data = d;
    n = 0;
    while (!req_ready && n < 2000) begin @(negedge clk); n++; end
    if (!req_ready) begin
      checkOutput("readyTimeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    if (a <= 7'(MAX_ADDR)) expReg[int'(a[2:0])] = d;
    @(posedge clk);
    #1;
    if (!keep) begin
      req_valid = 1'b0; req_addr = 7'($urandom); req_data = 8'($urandom);
    end
    if (noise && a <= 7'(MAX_ADDR)) begin
      gotDone = 0;
      for (int i = 0; i < 2000; i++) begin
        @(negedge clk);
        if (done) begin gotDone = 1; break; end
        req_valid = 1'($urandom); req_addr = 7'($urandom); req_data = 8'($urandom);
      end
      req_valid = 1'b0;
      if (!gotDone) checkOutput("doneTimeout", 32'(done), 32'd1);
    end
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!(req_ready && !busy) && n < 3000);
    if (!(req_ready && !busy)) checkOutput("idleTimeout", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0, f0, s0, n, s;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("resetVals", 32'({nCS, SCLK, COPI, busy, req_ready, done, err}), 32'b1000000);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("readyAfterRelease", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1 checkOutput("idleResetReady", 32'(req_ready), 32'd0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    checkOutput("readyAfterIdleReset", 32'(req_ready), 32'd1);

    d0 = doneCnt;
    applyStimulus(7'h04, 8'h80, 0, 0);
    waitIdle();
    checkOutput("single8480", 32'(rxQ[$]), 32'h8480);
    checkOutput("singleLow", 32'(lastLow), 32'd132);
    checkOutput("singleDone", 32'(doneCnt - d0), 32'd1);

    applyStimulus(7'h00, 8'hFF, 1, 0);
    applyStimulus(7'h02, 8'h0F, 0, 0);
    waitIdle();
    s = rxQ.size();
    checkOutput("b2bFirst", 32'(rxQ[s-2]), 32'h80FF);
    checkOutput("b2bSecond", 32'(rxQ[s-1]), 32'h820F);
    s = acceptCyc.size();
    checkOutput("b2bSpacing", 32'(acceptCyc[s-1] - acceptCyc[s-2]), 32'd137);
    checkOutput("b2bHigh", 32'(lastHigh), 32'(CS_GAP + 1));

    f0 = ncsFalls;
    applyStimulus(7'h05, 8'h33, 0, 0);
    @(negedge clk);
    checkOutput("errPulse", 32'({err, req_ready}), 32'b11);
    @(negedge clk);
    checkOutput("errWidth", 32'({err, req_ready, nCS, SCLK}), 32'b0110);
    checkOutput("errNoFrame", 32'(ncsFalls - f0), 32'd0);
    applyStimulus(7'h01, 8'hAA, 0, 0);
    waitIdle();
    checkOutput("afterErr81AA", 32'(rxQ[$]), 32'h81AA);

    d0 = doneCnt;
    s0 = sclkRises;
    applyStimulus(7'h03, 8'h12, 0, 0);
    n = 0;
    while (sclkRises < s0 + 7 && n < 1000) begin @(negedge clk); n++; end
    checkOutput("abortRises", 32'(sclkRises - s0), 32'd7);
    #2 reset = 1'b1;
    #1 checkOutput("abortPins", 32'({nCS, SCLK, COPI, busy, req_ready}), 32'b10000);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abortNoDone", 32'(doneCnt - d0), 32'd0);
    applyStimulus(7'h03, 8'h55, 0, 0);
    waitIdle();
    checkOutput("recover8355", 32'(rxQ[$]), 32'h8355);

    for (int a = 0; a < 5; a++) applyStimulus(7'(a), 8'($urandom), 0, 1);
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      applyStimulus(7'($urandom_range(0, 7)), 8'($urandom), 0, 1'($urandom));
    end
    waitIdle();
    checkOutput("pendingFrames", 32'(expQ.size()), 32'd0);
    for (int i = 0; i < 5; i++) checkOutput($sformatf("reg%0d", i), 32'(tgt[i]), 32'(expReg[i]));

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
